// File: rtl/plab3_mem_securememresponder.sv
// Cacheline memory responder with fixed response latency and a per-line secure bit.
// Non-secure requests that touch secure lines are refused with fail.
module plab3_mem_securememresponder #(
    parameter int p_mem_nbytes   = 1024,
    parameter int p_opaque_nbits = 8,
    parameter int p_latency      = 2,
    localparam int abw           = 32,
    localparam int clw           = 128,
    localparam int c_req_nbits   = 3 + p_opaque_nbits + abw + 4 + clw,
    localparam int c_resp_nbits  = 3 + p_opaque_nbits + 4 + clw
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [c_req_nbits-1:0]  memreq_msg,
    input  logic                    memreq_val,
    output logic                    memreq_rdy,
    input  logic                    memreq_domain,
    output logic [c_resp_nbits-1:0] memresp_msg,
    output logic                    memresp_val,
    input  logic                    memresp_rdy,
    output logic                    memresp_domain,
    output logic                    fail
);

    localparam int c_aw     = $clog2(p_mem_nbytes);
    localparam int c_iw     = c_aw - 4;
    localparam int c_nlines = p_mem_nbytes / 16;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    logic [2:0]                req_type;
    logic [p_opaque_nbits-1:0] req_opaque;
    logic [abw-1:0]            req_addr;
    logic [3:0]                req_len;
    logic [clw-1:0]            req_data;

    assign {req_type, req_opaque, req_addr, req_len, req_data} = memreq_msg;

    // Addresses wrap modulo the storage size; the byte offset within a line is ignored.
    logic [c_iw-1:0] idx;
    logic            unused_addr_bits;
    assign idx              = req_addr[c_aw-1:4];
    assign unused_addr_bits = ^{req_addr[abw-1:c_aw], req_addr[3:0]};

    logic [clw-1:0]        mem_q [c_nlines];
    logic [c_nlines-1:0]   sec_q;

    logic is_write, is_init, is_read, deny, fire, do_write;
    logic [clw-1:0] rd_data;

    always_comb begin
        is_write = (req_type == 3'd1);
        is_init  = (req_type == 3'd2);
        is_read  = !(is_write || is_init);
        deny     = sec_q[idx] && !memreq_domain && !is_init;
        fire     = memreq_val && memreq_rdy;
        do_write = fire && !is_read && !deny;
        rd_data  = (is_read && !deny) ? mem_q[idx] : '0;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        memreq_rdy  = 1'b0;
        memresp_val = 1'b0;
        case (state_q)
            S_IDLE: begin
                memreq_rdy = !reset;
                if (fire) begin
                    if (p_latency == 0) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(p_latency);
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = S_RESP;
            end
            S_RESP: begin
                memresp_val = !reset;
                if (memresp_rdy) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    logic [2:0]                resp_type_q;
    logic [p_opaque_nbits-1:0] resp_opaque_q;
    logic [3:0]                resp_len_q;
    logic [clw-1:0]            resp_data_q;
    logic                      fail_q, domain_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= 4'd0;
            sec_q         <= '0;
            resp_type_q   <= '0;
            resp_opaque_q <= '0;
            resp_len_q    <= '0;
            resp_data_q   <= '0;
            fail_q        <= 1'b0;
            domain_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (do_write) sec_q[idx] <= memreq_domain;
            if (fire) begin
                resp_type_q   <= req_type;
                resp_opaque_q <= req_opaque;
                resp_len_q    <= req_len;
                resp_data_q   <= rd_data;
                fail_q        <= deny;
                domain_q      <= memreq_domain;
            end
        end
    end

    // NOTE: the data array is deliberately not reset; only the secure bits carry reset state.
    always_ff @(posedge clk) begin
        if (do_write) mem_q[idx] <= req_data;
    end

    assign memresp_msg    = {resp_type_q, resp_opaque_q, resp_len_q, resp_data_q};
    assign memresp_domain = domain_q;
    assign fail           = fail_q;

endmodule

// File: tb/tb_plab3_mem_securememresponder.sv
// Scoreboard bench: a latency-2 and a latency-0 responder share stimulus, selected by sel.
module tb_plab3_mem_securememresponder;

    localparam int REQW  = 3 + 8 + 32 + 4 + 128;
    localparam int RESPW = 3 + 8 + 4 + 128;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset;
    logic            sel;
    logic [REQW-1:0] req_msg;
    logic            req_val, req_dom, resp_rdy;

    logic [1:0]       d_req_rdy, d_resp_val, d_resp_dom, d_fail;
    logic [RESPW-1:0] d_resp_msg [2];

    plab3_mem_securememresponder #(.p_mem_nbytes(1024), .p_opaque_nbits(8), .p_latency(2)) dut (
        .clk(clk), .reset(reset),
        .memreq_msg(req_msg), .memreq_val(req_val & ~sel), .memreq_rdy(d_req_rdy[0]),
        .memreq_domain(req_dom),
        .memresp_msg(d_resp_msg[0]), .memresp_val(d_resp_val[0]), .memresp_rdy(resp_rdy & ~sel),
        .memresp_domain(d_resp_dom[0]), .fail(d_fail[0])
    );

    plab3_mem_securememresponder #(.p_mem_nbytes(1024), .p_opaque_nbits(8), .p_latency(0)) dut_l0 (
        .clk(clk), .reset(reset),
        .memreq_msg(req_msg), .memreq_val(req_val & sel), .memreq_rdy(d_req_rdy[1]),
        .memreq_domain(req_dom),
        .memresp_msg(d_resp_msg[1]), .memresp_val(d_resp_val[1]), .memresp_rdy(resp_rdy & sel),
        .memresp_domain(d_resp_dom[1]), .fail(d_fail[1])
    );

    logic             o_req_rdy, o_resp_val, o_resp_dom, o_fail;
    logic [RESPW-1:0] o_resp_msg;
    assign o_req_rdy  = d_req_rdy[sel];
    assign o_resp_val = d_resp_val[sel];
    assign o_resp_dom = d_resp_dom[sel];
    assign o_fail     = d_fail[sel];
    assign o_resp_msg = d_resp_msg[sel];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0]   typ;
        logic [7:0]   opq;
        logic [3:0]   len;
        logic [127:0] data;
        logic         fail;
        logic         dom;
        int           fire_cyc;
    } exp_t;

    exp_t         exp_q [$];
    logic [127:0] model_mem [2][64];
    logic         model_sec [2][64];
    int           errors = 0;
    int           checks = 0;
    int           last_fire = 0;

    localparam logic [127:0] D_A5   = {16{8'hA5}};
    localparam logic [127:0] D_1234 = 128'h1234;
    localparam logic [127:0] D_410  = 128'hCAFE_F00D_0000_0410;
    localparam logic [127:0] D_300  = 128'h3003_3003;

    task automatic clear_model_sec();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 64; i++) model_sec[d][i] = 1'b0;
    endtask

    // Drives one request until it is accepted and pushes the model's expected response.
    task automatic send(input logic [2:0] typ, input logic [31:0] addr, input logic dom,
                        input logic [127:0] data, input logic [7:0] opq);
        exp_t       e;
        logic [5:0] idx;
        logic       lock;
        bit         fired = 0;
        req_msg = {typ, opq, addr, 4'd0, data};
        req_dom = dom;
        req_val = 1'b1;
        for (int i = 0; i < 40 && !fired; i++) begin
            if (o_req_rdy === 1'b1) fired = 1;
            else @(negedge clk);
        end
        checks++;
        if (!fired) begin
            errors++;
            $display("FAIL send_accept: memreq_rdy never 1 within 40 cycles (addr %h)", addr);
            req_val = 1'b0;
            return;
        end
        idx   = addr[9:4];
        lock  = model_sec[sel][idx] && !dom;
        e.typ = typ;
        e.opq = opq;
        e.len = 4'd0;
        e.dom = dom;
        case (typ)
            3'd1: begin
                e.fail = lock;
                e.data = '0;
                if (!lock) begin
                    model_mem[sel][idx] = data;
                    model_sec[sel][idx] = dom;
                end
            end
            3'd2: begin
                e.fail = 1'b0;
                e.data = '0;
                model_mem[sel][idx] = data;
                model_sec[sel][idx] = dom;
            end
            default: begin
                e.fail = lock;
                e.data = lock ? '0 : model_mem[sel][idx];
            end
        endcase
        e.fire_cyc = cyc;
        last_fire  = cyc;
        exp_q.push_back(e);
        @(negedge clk);
        req_val = 1'b0;
    endtask

    // Waits for the response, compares it to the scoreboard head, optionally stalls it.
    task automatic recv(input string name, input int hold);
        exp_t             e;
        logic [RESPW-1:0] exp_msg;
        bit               seen = 0;
        int               lat  = sel ? 0 : 2;
        resp_rdy = (hold == 0);
        for (int i = 0; i < 40 && !seen; i++) begin
            if (o_resp_val === 1'b1) seen = 1;
            else @(negedge clk);
        end
        checks++;
        if (!seen || exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s_resp: memresp_val=%b queued=%0d, required a response", name, o_resp_val, exp_q.size());
            resp_rdy = 1'b0;
            return;
        end
        e = exp_q.pop_front();
        exp_msg = {e.typ, e.opq, e.len, e.data};
        checks++;
        if (cyc - e.fire_cyc !== 1 + lat) begin
            errors++;
            $display("FAIL %s_latency: got %0d cycles, required %0d", name, cyc - e.fire_cyc, 1 + lat);
        end
        checks++;
        if (o_resp_msg !== exp_msg) begin
            errors++;
            $display("FAIL %s_msg: got %h required %h", name, o_resp_msg, exp_msg);
        end
        checks++;
        if (o_fail !== e.fail) begin
            errors++;
            $display("FAIL %s_fail: got %b required %b", name, o_fail, e.fail);
        end
        checks++;
        if (o_resp_dom !== e.dom) begin
            errors++;
            $display("FAIL %s_domain: got %b required %b", name, o_resp_dom, e.dom);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checks++;
            if (o_resp_val !== 1'b1 || o_resp_msg !== exp_msg || o_fail !== e.fail || o_req_rdy !== 1'b0) begin
                errors++;
                $display("FAIL %s_hold%0d: val=%b rdy=%b fail=%b msg=%h, required val=1 rdy=0 fail=%b msg=%h",
                         name, i, o_resp_val, o_req_rdy, o_fail, o_resp_msg, e.fail, exp_msg);
            end
        end
        resp_rdy = 1'b1;
        @(negedge clk);
        resp_rdy = 1'b0;
        checks++;
        if (o_resp_val !== 1'b0 || o_req_rdy !== 1'b1 || o_fail !== e.fail || o_resp_dom !== e.dom) begin
            errors++;
            $display("FAIL %s_after: val=%b rdy=%b fail=%b dom=%b, required val=0 rdy=1 fail=%b dom=%b",
                     name, o_resp_val, o_req_rdy, o_fail, o_resp_dom, e.fail, e.dom);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (d_req_rdy !== 2'b00 || d_resp_val !== 2'b00) begin
            errors++;
            $display("FAIL reset_during: req_rdy=%b resp_val=%b, required 00 00", d_req_rdy, d_resp_val);
        end
        reset = 1'b0;
        clear_model_sec();
        @(negedge clk);
        checks++;
        if (o_req_rdy !== 1'b1 || o_resp_val !== 1'b0 || o_fail !== 1'b0 || o_resp_dom !== 1'b0 ||
            o_resp_msg !== '0) begin
            errors++;
            $display("FAIL reset_after: rdy=%b val=%b fail=%b dom=%b msg=%h, required 1 0 0 0 0",
                     o_req_rdy, o_resp_val, o_fail, o_resp_dom, o_resp_msg);
        end
    endtask

    task automatic test_init_read();
        send(3'd2, 32'h100, 1'b0, D_A5, 8'h11);
        recv("init_100", 0);
        send(3'd0, 32'h100, 1'b0, '0, 8'h5C);
        recv("read_100", 0);
    endtask

    task automatic test_secure();
        send(3'd1, 32'h200, 1'b1, D_1234, 8'h21);
        recv("sec_write_200", 0);
        send(3'd0, 32'h200, 1'b0, '0, 8'h22);
        recv("ns_read_200", 0);
        send(3'd0, 32'h200, 1'b1, '0, 8'h23);
        recv("sec_read_200", 0);
    endtask

    task automatic test_ns_write_refused();
        send(3'd1, 32'h200, 1'b0, 128'hDEAD, 8'h31);
        recv("ns_write_200", 0);
        send(3'd0, 32'h208, 1'b1, '0, 8'h32);
        recv("sec_reread_200", 0);
    endtask

    task automatic test_odd_type();
        send(3'd5, 32'h10C, 1'b1, 128'hFFFF, 8'h41);
        recv("type5_as_read", 0);
    endtask

    task automatic test_backpressure();
        send(3'd0, 32'h100, 1'b0, '0, 8'h51);
        recv("stall_read", 5);
    endtask

    task automatic test_back_to_back();
        int first;
        send(3'd0, 32'h100, 1'b0, '0, 8'h61);
        first = last_fire;
        recv("b2b_a", 0);
        send(3'd0, 32'h200, 1'b1, '0, 8'h62);
        checks++;
        if (last_fire - first !== 4) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d cycles, required 4", last_fire - first);
        end
        recv("b2b_b", 0);
    endtask

    task automatic test_wrap_lat0();
        sel = 1'b1;
        @(negedge clk);
        send(3'd1, 32'h0000_0410, 1'b0, D_410, 8'h71);
        recv("l0_write_410", 0);
        send(3'd0, 32'h0000_0010, 1'b0, '0, 8'h72);
        recv("l0_read_010", 0);
        sel = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_wait();
        send(3'd1, 32'h300, 1'b1, D_300, 8'h81);
        reset = 1'b1;
        void'(exp_q.pop_back());
        clear_model_sec();
        @(negedge clk);
        checks++;
        if (o_resp_val !== 1'b0 || o_req_rdy !== 1'b0) begin
            errors++;
            $display("FAIL midwait_reset: val=%b rdy=%b, required 0 0", o_resp_val, o_req_rdy);
        end
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (o_resp_val !== 1'b0 || o_req_rdy !== 1'b1) begin
                errors++;
                $display("FAIL midwait_quiet%0d: val=%b rdy=%b, required 0 1", i, o_resp_val, o_req_rdy);
            end
        end
        send(3'd0, 32'h300, 1'b0, '0, 8'h82);
        recv("post_reset_300", 0);
        send(3'd0, 32'h200, 1'b0, '0, 8'h83);
        recv("post_reset_200", 0);
    endtask

    initial begin
        reset    = 1'b1;
        sel      = 1'b0;
        req_msg  = '0;
        req_val  = 1'b0;
        req_dom  = 1'b0;
        resp_rdy = 1'b0;
        clear_model_sec();
        test_reset();
        test_init_read();
        test_secure();
        test_ns_write_refused();
        test_odd_type();
        test_backpressure();
        test_back_to_back();
        test_wrap_lat0();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/plab3_mem_securememresponder.md
# plab3_mem_SecureMemResponder

Single-ported, cacheline-wide memory responder that sits on the memory side of the blocking L1 cache. It accepts cacheline memory requests and returns memory responses with a programmable fixed latency. It keeps one secure bit per line and enforces domain isolation: non-secure requests touching secure lines are refused with `fail`. It serves as the backing store and security checker for cache integration tests and for system builds without a real L2.

## Interface
- `p_mem_nbytes`, 1024: storage size in bytes; power of two; lines = p_mem_nbytes/16.
- `p_opaque_nbits`, 8: opaque field width (`o`).
- `p_latency`, 2: extra cycles between request accept and response valid; 0–15.
- `abw`, 32 / `clw`, 128: address and line widths; local, not overridden.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `memreq_msg` in `VC_MEM_REQ_MSG_NBITS(o,abw,clw)`: {type, opaque, addr, len, data}.
- `memreq_val` in 1 / `memreq_rdy` out 1: request handshake.
- `memreq_domain` in 1: requester domain; 1 = secure, 0 = non-secure.
- `memresp_msg` out `VC_MEM_RESP_MSG_NBITS(o,clw)`: {type, opaque, len, data}.
- `memresp_val` out 1 / `memresp_rdy` in 1: response handshake.
- `memresp_domain` out 1: domain of the request being answered.
- `fail` out 1: access refused; qualified by `memresp_val`.

## Operation
- Storage: `nlines` × 128-bit data array (not reset). `sec[nlines]` secure bits, cleared on reset.
- Line index = addr[log2(p_mem_nbytes)-1:4]. Higher address bits are ignored, so addresses wrap modulo the size. addr[3:0] is ignored.
- Type codes: 0 = read, 1 = write, 2 = write-init. Other codes are handled as read.
- Read:
  - If `sec[idx]` = 1 and domain = 0: `fail`=1 and response data = 0.
  - Otherwise: `fail`=0 and data = line.
- Write / write-init:
  - If `sec[idx]` = 1 and domain = 0 (plain write only): the write is dropped and `fail`=1.
  - Otherwise: the line is written and `sec[idx]` ← domain.
  - Write-init never fails.
  - Write response data = 0.
- Len: full-line only; len is echoed unchanged and does not mask the write.
- Response type and opaque echo the request. `memresp_domain` = captured request domain.
- FSM:
  - IDLE: `memreq_rdy`=1. On fire (val&rdy), capture type, opaque, len, domain and the read result; perform the write/secure update at the same edge. Go to WAIT with cnt=p_latency, or go directly to RESP if p_latency=0.
  - WAIT: `memreq_rdy`=0. Decrement cnt; at cnt==1 go to RESP.
  - RESP: `memresp_val`=1 and all response fields are held stable. On `memresp_rdy` go to IDLE.
- Only one request is outstanding at a time; there is no pipelining.

## Timing
- Reset values (during the reset cycle and the first cycle after it):
  - state = IDLE, `memreq_rdy`=0 while reset is high.
  - `memresp_val`=0, `fail`=0, `memresp_domain`=0, `memresp_msg`=0, all `sec`=0.
- Request fire at cycle T → `memresp_val` rises at T+1+p_latency.
- Earliest next accept is the cycle after the response fires. Back-to-back throughput is one request per 2+p_latency cycles.
- `memresp_rdy` held low: the response and `fail` hold indefinitely; `memreq_rdy` stays 0.
- `memresp_rdy` high already in the first RESP cycle: the response fires that cycle.
- A read fired at T returns data as of before any write in T. No other write can occur in T, since there is a single port.
- Reset asserted mid-WAIT or mid-RESP: the pending response is discarded and the next cycle is IDLE. A write already performed at accept is kept, but `sec` is cleared.
- `memresp_domain` and `fail` change only on request accept; they hold after the response fires until the next accept.

## Test plan
- Reset, then write-init line 0x100 with domain 0 and data 0xA5…A5, then read 0x100 with domain 0 → response at T+3 (p_latency=2) carries the data, `fail`=0 and the echoed opaque.
- Secure write to 0x200 (domain 1, data 0x1234), then non-secure read of 0x200 → `fail`=1, data=0, `memresp_domain`=0. Secure read of 0x200 → 0x1234 with `fail`=0.
- Non-secure write to secure line 0x200 → `fail`=1. A following secure read still returns 0x1234.
- Hold `memresp_rdy`=0 for 5 cycles → response stable, `memreq_rdy`=0 throughout. Release → `memreq_rdy`=1 on the next cycle.
- Wrap: with p_mem_nbytes=1024, write 0x0000_0410 and read 0x0000_0010 → same data. p_latency=0 → response at T+1.
- Assert reset during WAIT → no response appears. Afterwards a non-secure read of the previously secure line succeeds with `fail`=0.
